// File: rtl/usp_reg_pkg.sv
// Shared definitions for the USP registration responder.
//   state_e          : responder FSM states
//   status_e         : m2_status response codes
//   HASH_IV/HASH_RC  : Aj hash initial value and round constant
//   hash_round()     : one round of the Aj hash
//   DEFAULT_ACCEPTABLE_DELAY : default freshness window for M1
package usp_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_HASH,
    ST_BUILD,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    STAT_OK    = 2'b00,
    STAT_STALE = 2'b01,
    STAT_DUP   = 2'b10,
    STAT_FULL  = 2'b11
  } status_e;

  localparam logic [63:0] HASH_IV = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] HASH_RC = 64'hC3C3_C3C3_C3C3_C3C3;
  localparam int unsigned DEFAULT_ACCEPTABLE_DELAY = 10;

  // Every term uses the pre-round state s; the round constant is shifted
  // right by 9 bits per round index.
  function automatic logic [63:0] hash_round(input logic [63:0] s,
                                             input logic [63:0] d,
                                             input logic [1:0]  idx);
    logic [63:0] rc;
    rc = HASH_RC >> (9 * idx);
    return (s ^ d) ^ ((s << 3) ^ (s >> 5)) ^ rc;
  endfunction

endpackage

// File: rtl/usp_hash192_iter.sv
// Iterative Aj hash: one 64-bit round per cycle over a 256-bit message,
// consuming word 0 (bits 63:0) first.
//   clk     : clock
//   rst     : synchronous active-low reset (clears hash state)
//   start_i : load the IV; rounds run on the following four cycles
//   data_i  : message, held stable by the caller while busy
//   done_o  : high in the cycle whose closing edge applies the last round
//   hash_o  : current hash state (final Aj once done_o has been seen)
module usp_hash192_iter
  import usp_reg_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [255:0] data_i,
  output logic         done_o,
  output logic [63:0]  hash_o
);

  logic [63:0] s_q, s_d;
  logic [1:0]  rnd_q, rnd_d;
  logic        busy_q, busy_d;

  always_comb begin
    s_d    = s_q;
    rnd_d  = rnd_q;
    busy_d = busy_q;
    if (start_i) begin
      s_d    = HASH_IV;
      rnd_d  = 2'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      s_d   = hash_round(s_q, data_i[{rnd_q, 6'd0} +: 64], rnd_q);
      rnd_d = rnd_q + 2'd1;
      if (rnd_q == 2'd3) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q    <= '0;
      rnd_q  <= 2'd0;
      busy_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      rnd_q  <= rnd_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = busy_q && (rnd_q == 2'd3);
  assign hash_o = s_q;

endmodule

// File: rtl/usp_registration_responder.sv
// USP registration responder: decrypts an EV's M1, checks freshness and the
// pseudonym table, computes Aj and returns an encrypted M2 (or a zeroed
// reject with a status code).
//   clk, rst                   : clock, synchronous active-low reset
//   m1_valid/m1_ready/m1_data  : M1 handshake and encrypted payload
//   t1_in, now_ts              : EV send time, responder time
//   common_key, usp_id_j, usp_pub_key_j : static key and USP identity
//   tbl_clr                    : clear all registered pseudonyms
//   m2_valid/m2_ready/m2_data/m2_status : response handshake and payload
//   reg_count                  : number of valid table entries
module usp_registration_responder
  import usp_reg_pkg::*;
#(
  parameter int unsigned ACCEPTABLE_DELAY = DEFAULT_ACCEPTABLE_DELAY,
  parameter int unsigned TABLE_DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m1_valid,
  output logic                         m1_ready,
  input  logic [255:0]                 m1_data,
  input  logic [63:0]                  t1_in,
  input  logic [63:0]                  now_ts,
  input  logic [63:0]                  common_key,
  input  logic [63:0]                  usp_id_j,
  input  logic [63:0]                  usp_pub_key_j,
  input  logic                         tbl_clr,
  output logic                         m2_valid,
  input  logic                         m2_ready,
  output logic [191:0]                 m2_data,
  output logic [1:0]                   m2_status,
  output logic [$clog2(TABLE_DEPTH):0] reg_count
);

  localparam int CNT_W = $clog2(TABLE_DEPTH) + 1;

  state_e                 state_q, state_d;
  logic [191:0]           m1_q;          // decrypted {psidev, ev_ch, rs}
  logic [63:0]            t1_q, now_q;
  logic [191:0]           m2_data_q, m2_data_d;
  status_e                m2_status_q, m2_status_d;
  logic [TABLE_DEPTH-1:0] valid_q, valid_d, ins_oh;
  logic [63:0]            psid_q [TABLE_DEPTH];
  logic                   hash_start, hash_done, ins_en;
  logic                   stale, dup, full, found;
  logic [63:0]            hash_val, psidev;
  logic [CNT_W-1:0]       cnt;
  logic                   unused_evpk;

  // The EV public key rides along in M1 but plays no part in the response.
  assign unused_evpk = ^m1_data[63:0];

  assign psidev   = m1_q[191:128];
  assign m1_ready = (state_q == ST_IDLE);
  assign m2_valid = (state_q == ST_RESP);

  usp_hash192_iter u_hash (
    .clk     (clk),
    .rst     (rst),
    .start_i (hash_start),
    .data_i  ({m1_q, usp_id_j}),
    .done_o  (hash_done),
    .hash_o  (hash_val)
  );

  // A timestamp from the future is stale; the subtraction cannot wrap once
  // t1 <= now has been established.
  always_comb begin
    stale = (t1_q > now_q) || ((now_q - t1_q) > 64'(ACCEPTABLE_DELAY));
    dup   = 1'b0;
    for (int i = 0; i < int'(TABLE_DEPTH); i++)
      if (valid_q[i] && (psid_q[i] == psidev)) dup = 1'b1;
    full = &valid_q;
  end

  always_comb begin
    state_d     = state_q;
    m2_data_d   = m2_data_q;
    m2_status_d = m2_status_q;
    hash_start  = 1'b0;
    ins_en      = 1'b0;
    case (state_q)
      ST_IDLE:  if (m1_valid) state_d = ST_CHECK;
      ST_CHECK: begin
        if (stale || dup || full) begin
          state_d     = ST_RESP;
          m2_data_d   = '0;
          m2_status_d = stale ? STAT_STALE : (dup ? STAT_DUP : STAT_FULL);
        end else begin
          state_d    = ST_HASH;
          hash_start = 1'b1;
        end
      end
      ST_HASH:  if (hash_done) state_d = ST_BUILD;
      ST_BUILD: begin
        m2_data_d   = {hash_val, usp_id_j, usp_pub_key_j} ^ {3{common_key}};
        m2_status_d = STAT_OK;
        ins_en      = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP:  if (m2_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Insert into the lowest-index free slot; a same-cycle clear wins.
  always_comb begin
    valid_d = valid_q;
    ins_oh  = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(TABLE_DEPTH); i++) begin
      if (ins_en && !found && !valid_q[i]) begin
        ins_oh[i]  = 1'b1;
        valid_d[i] = 1'b1;
        found      = 1'b1;
      end
    end
    if (tbl_clr) valid_d = '0;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < int'(TABLE_DEPTH); i++)
      cnt = cnt + CNT_W'(valid_q[i]);
  end
  assign reg_count = cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      m2_data_q   <= '0;
      m2_status_q <= STAT_OK;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      m2_data_q   <= m2_data_d;
      m2_status_q <= m2_status_d;
      valid_q     <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (m1_valid && m1_ready) begin
      m1_q  <= m1_data[255:64] ^ {3{common_key}};
      t1_q  <= t1_in;
      now_q <= now_ts;
    end
    for (int i = 0; i < int'(TABLE_DEPTH); i++)
      if (ins_oh[i]) psid_q[i] <= psidev;
  end

  assign m2_data   = m2_data_q;
  assign m2_status = m2_status_q;

endmodule

// File: doc/usp_registration_responder.md
USP_REGISTRATION_RESPONDER -- requirements
Module: usp_registration_responder

Interface
REQ-001 Parameter ACCEPTABLE_DELAY, default 10, is the maximum allowed now_ts - t1_in for a fresh M1.
REQ-002 Parameter TABLE_DEPTH, default 4, is the number of registered pseudonym slots.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 m1_valid  in  1  M1 offered by EV.
REQ-006 m1_ready  out  1  responder accepts M1.
REQ-007 m1_data  in  256  encrypted {psidev, ev_ch, rs, ev_pub_key}, psidev in [255:192].
REQ-008 t1_in  in  64  EV send timestamp, qualified by m1_valid.
REQ-009 now_ts  in  64  free-running responder time.
REQ-010 common_key, usp_id_j, usp_pub_key_j  in  64 each  static key and USP identity.
REQ-011 tbl_clr  in  1  clear registration table.
REQ-012 m2_valid  out  1  response present.
REQ-013 m2_ready  in  1  consumer takes response.
REQ-014 m2_data  out  192  encrypted {Aj, usp_id_j, usp_pub_key_j}; zero on reject.
REQ-015 m2_status  out  2  00 OK, 01 STALE, 10 DUPLICATE, 11 FULL.
REQ-016 reg_count  out  $clog2(TABLE_DEPTH)+1  valid table entries.

Function
REQ-017 FSM states IDLE, CHECK, HASH, BUILD, RESP; m1_ready = 1 only in IDLE.
REQ-018 Accept on m1_valid && m1_ready: capture m1_data ^ {4{common_key}}, t1_in and now_ts; go to CHECK.
REQ-019 CHECK: STALE if t1 > now or now - t1 > ACCEPTABLE_DELAY (64-bit unsigned, no wrap); else DUPLICATE if a valid entry equals psidev; else FULL if all entries valid; priority STALE > DUPLICATE > FULL.
REQ-020 CHECK reject -> RESP with m2_data = 0 and that status; pass -> HASH.
REQ-021 HASH: 4 cycles over D = {psidev, ev_ch, rs, usp_id_j}; s0 = A5A5A5A5A5A5A5A5; round i (0..3): s = (s ^ D[i*64+:64]) ^ ((s << 3) ^ (s >> 5)) ^ (C3C3C3C3C3C3C3C3 >> 9i); logical shifts, 64-bit truncation; Aj = final s.
REQ-022 BUILD: m2_data = {Aj, usp_id_j, usp_pub_key_j} ^ {3{common_key}}, status OK; write psidev into lowest-index free slot; -> RESP.
REQ-023 Latency from accept edge N: reject m2_valid at N+2; success m2_valid at N+7.
REQ-024 RESP: m2_valid = 1, m2_data/m2_status stable until m2_valid && m2_ready; then IDLE, with m1_ready = 1 in the next cycle.
REQ-025 m2_valid = 0 in all states other than RESP.
REQ-026 tbl_clr is sampled every cycle; all entries invalid next cycle; same-cycle clear beats BUILD insert.
REQ-027 reg_count equals the number of valid entries, updated in the cycle after insert or clear.

Reset
REQ-028 rst low at a clock edge: state IDLE, m2_valid 0, m2_data 0, m2_status 00, reg_count 0, all entries invalid, hash state 0.
REQ-029 Reset mid-transaction drops it, issues no response and inserts no entry.

Structure
REQ-030 Shared package usp_reg_pkg holds the FSM state enum, the status codes, the hash IV and round constant, and ACCEPTABLE_DELAY default.
REQ-031 One sub-module usp_hash192_iter (start/done, one round per cycle) implements REQ-021; the table and FSM stay in the top.

Verification
REQ-032 key=0, t1=100, now=104, fresh psidev=0x1111... -> m2_valid at N+7, status 00, m2_data[191:128] = golden hash, reg_count 1.
REQ-033 Same psidev resent, now-t1=3 -> m2_valid at N+2, status 10, m2_data 0, reg_count unchanged.
REQ-034 t1=100, now=111 -> status 01; t1=200, now=150 -> status 01; t1=100, now=110 -> accepted.
REQ-035 Five distinct fresh pseudonyms with TABLE_DEPTH=4 -> four 00 then 11; tbl_clr then resend fifth -> 00, reg_count 1.
REQ-036 m2_ready held 0 for 5 cycles in RESP -> m2_data/status stable, m1_ready 0 throughout; release -> m1_ready 1 next cycle.
REQ-037 rst low during HASH -> no m2_valid, reg_count 0, next M1 processed normally.
